// File: rtl/aes_data_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_data_loader_pkg
// Brief    : Shared AES block sizes and loader state encoding.
// Revision : 1.0
// ============================================================================
package aes_data_loader_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_COUNT_BITS  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TEXT      = 3'd1,
        TEXT_DONE = 3'd2,
        KEY       = 3'd3,
        KEY_DONE  = 3'd4
    } loader_state_t;

endpackage : aes_data_loader_pkg
`default_nettype wire

// File: rtl/aes_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : aes_byte_assembler
// Brief    : 128-bit byte shift register with a 4-bit byte counter.
// Revision : 1.0
// ============================================================================
module aes_byte_assembler
    import aes_data_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_clear,
    input  logic                      i_shift,
    input  logic [7:0]                i_byte,
    output logic [AES_BLOCK_BITS-1:0] o_next,
    output logic                      o_last
);

    logic [AES_BLOCK_BITS-1:0] r_shift;
    logic [AES_COUNT_BITS-1:0] r_count;
    logic [AES_BLOCK_BITS-1:0] w_shifted;

    // Value the register takes if i_byte is shifted in this cycle; lets the
    // caller capture the full block on the same edge as the last byte.
    assign w_shifted = (r_shift << 8) | {{(AES_BLOCK_BITS-8){1'b0}}, i_byte};
    assign o_next    = w_shifted;
    assign o_last    = (r_count == AES_COUNT_BITS'(AES_BLOCK_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_shift) begin
            r_shift <= w_shifted;
            r_count <= r_count + 1'b1;
        end
    end

endmodule : aes_byte_assembler
`default_nettype wire

// File: rtl/aes_data_loader.sv
`default_nettype none
// ============================================================================
// Module   : aes_data_loader
// Brief    : Collects 16 plaintext bytes then 16 key bytes into 128-bit blocks.
// Revision : 1.0
// ============================================================================
module aes_data_loader
    import aes_data_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_load,
    input  logic                      i_byte_valid,
    input  logic [7:0]                i_byte,
    output logic                      o_byte_ready,
    output logic [AES_BLOCK_BITS-1:0] data,
    output logic                      o_data_received_text,
    output logic                      o_data_received_key,
    output logic                      o_busy
);

    loader_state_t             r_state;
    logic                      r_load_q;
    logic                      r_ready;
    logic                      r_busy;
    logic                      r_text;
    logic                      r_key;
    logic [AES_BLOCK_BITS-1:0] r_data;

    logic                      w_start;
    logic                      w_accept;
    logic                      w_clear;
    logic                      w_last;
    logic [AES_BLOCK_BITS-1:0] w_next;

    assign w_start  = i_load && !r_load_q;
    assign w_accept = i_byte_valid && r_ready;
    // Counter restarts on entry to either byte-collecting state.
    assign w_clear  = ((r_state == IDLE) && w_start) || (r_state == TEXT_DONE);

    aes_byte_assembler u_assembler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_shift (w_accept),
        .i_byte  (i_byte),
        .o_next  (w_next),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_load_q <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_text   <= 1'b0;
            r_key    <= 1'b0;
            r_data   <= '0;
        end else begin
            r_load_q <= i_load;
            r_text   <= 1'b0;
            r_key    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= TEXT;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                TEXT: begin
                    if (w_accept && w_last) begin
                        r_state <= TEXT_DONE;
                        r_ready <= 1'b0;
                        r_text  <= 1'b1;
                        r_data  <= w_next;
                    end
                end
                TEXT_DONE: begin
                    r_state <= KEY;
                    r_ready <= 1'b1;
                end
                KEY: begin
                    if (w_accept && w_last) begin
                        r_state <= KEY_DONE;
                        r_ready <= 1'b0;
                        r_key   <= 1'b1;
                        r_data  <= w_next;
                    end
                end
                KEY_DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte_ready         = r_ready;
    assign o_busy               = r_busy;
    assign o_data_received_text = r_text;
    assign o_data_received_key  = r_key;
    assign data                 = r_data;

endmodule : aes_data_loader
`default_nettype wire

// File: tb/tb_aes_data_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_data_loader
// Brief    : Scoreboard bench for aes_data_loader with directed byte streams.
// Revision : 1.0
// ============================================================================
module tb_aes_data_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_load = 1'b0;
    logic         i_byte_valid = 1'b0;
    logic [7:0]   i_byte = 8'h00;
    logic         o_byte_ready;
    logic [127:0] data;
    logic         o_data_received_text;
    logic         o_data_received_key;
    logic         o_busy;

    typedef struct packed {
        logic         is_key;
        logic [127:0] blk;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] txt_bytes [16] = '{8'h54, 8'h77, 8'h6F, 8'h20, 8'h4F, 8'h6E, 8'h65, 8'h20,
                                   8'h4E, 8'h69, 8'h6E, 8'h65, 8'h20, 8'h54, 8'h77, 8'h6F};
    logic [7:0] key_bytes [16] = '{8'h54, 8'h68, 8'h61, 8'h74, 8'h73, 8'h20, 8'h6D, 8'h79,
                                   8'h20, 8'h4B, 8'h75, 8'h6E, 8'h67, 8'h20, 8'h46, 8'h75};
    logic [127:0] exp_text = 128'h54776F204F6E65204E696E652054776F;
    logic [127:0] exp_key  = 128'h5468617473206D79204B756E67204675;

    aes_data_loader dut (
        .clk                  (clk),
        .reset                (reset),
        .i_load               (i_load),
        .i_byte_valid         (i_byte_valid),
        .i_byte               (i_byte),
        .o_byte_ready         (o_byte_ready),
        .data                 (data),
        .o_data_received_text (o_data_received_text),
        .o_data_received_key  (o_data_received_key),
        .o_busy               (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset && (o_data_received_text || o_data_received_key)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {126'd0, o_data_received_key, o_data_received_text}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.is_key ? "key_pulse_kind" : "text_pulse_kind",
                      {126'd0, o_data_received_key, o_data_received_text},
                      e.is_key ? 128'd2 : 128'd1);
                check(e.is_key ? "key_data" : "text_data", data, e.blk);
                check("ready_low_in_done", {127'd0, o_byte_ready}, 128'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit ok;
        if (maxgap > 0) begin
            i_byte_valid = 1'b0;
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
            #1;
        end
        i_byte_valid = 1'b1;
        i_byte       = b;
        ok = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            ok = o_byte_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("byte_accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic send_all(input int maxgap);
        for (int i = 0; i < 16; i++) send_byte(txt_bytes[i], maxgap);
        for (int i = 0; i < 16; i++) send_byte(key_bytes[i], maxgap);
        i_byte_valid = 1'b0;
    endtask

    task automatic pulse_load();
        i_load = 1'b1;
        @(posedge clk); #1;
        i_load = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 400 && !idle; c++) begin
            @(negedge clk);
            idle = !o_busy;
        end
        check(name, {127'd0, idle}, 128'd1);
        check("ready_idle", {127'd0, o_byte_ready}, 128'd0);
    endtask

    task automatic expect_blocks();
        sb.push_back('{is_key: 1'b0, blk: exp_text});
        sb.push_back('{is_key: 1'b1, blk: exp_key});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {127'd0, o_byte_ready}, 128'd0);
        check({tag, "_text"},  {127'd0, o_data_received_text}, 128'd0);
        check({tag, "_key"},   {127'd0, o_data_received_key}, 128'd0);
        check({tag, "_busy"},  {127'd0, o_busy}, 128'd0);
        check({tag, "_data"},  data, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Nominal back-to-back load; valid stays high across TEXT_DONE
        expect_blocks();
        pulse_load();
        send_all(0);
        wait_idle("nominal_idle");

        // Random valid gaps
        repeat (3) @(posedge clk); #1;
        expect_blocks();
        pulse_load();
        send_all(5);
        wait_idle("gaps_idle");

        // i_load held high, re-pulsed mid-KEY, still high after KEY_DONE
        repeat (3) @(posedge clk); #1;
        expect_blocks();
        i_load = 1'b1;
        fork
            begin
                repeat (24) @(posedge clk); #1;
                i_load = 1'b0;
                @(posedge clk); #1;
                i_load = 1'b1;
                repeat (34) @(posedge clk);
                @(negedge clk);
                check("retrigger_no_restart", {127'd0, o_busy}, 128'd0);
                @(posedge clk); #1;
                i_load = 1'b0;
            end
            send_all(0);
        join
        wait_idle("retrigger_idle");

        // Reset after 7 text bytes
        repeat (3) @(posedge clk); #1;
        pulse_load();
        for (int i = 0; i < 7; i++) send_byte(txt_bytes[i], 0);
        reset = 1'b1;
        #2;
        check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("mid_reset");
        i_byte_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_reset_idle", {127'd0, o_busy}, 128'd0);
        @(posedge clk); #1;
        expect_blocks();
        pulse_load();
        send_all(0);
        wait_idle("post_reset_final_idle");

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_aes_data_loader
`default_nettype wire

// File: doc/aes_data_loader.md
AES_DATA_LOADER -- requirements
Module: aes_data_loader

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port i_load  input  1  load request from the main FSM (its o_load); acted on at its rising edge only.
REQ-004 SHALL have port i_byte_valid  input  1  upstream byte present on i_byte.
REQ-005 SHALL have port i_byte  input  8  upstream byte, plaintext first then key, most-significant byte first.
REQ-006 SHALL have port o_byte_ready  output  1  loader accepts i_byte this cycle.
REQ-007 SHALL have port data  output  128  assembled block (text or key) presented to the FSMs.
REQ-008 SHALL have port o_data_received_text  output  1  one-cycle pulse: data holds the complete plaintext.
REQ-009 SHALL have port o_data_received_key  output  1  one-cycle pulse: data holds the complete key.
REQ-010 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, TEXT, TEXT_DONE, KEY, KEY_DONE.
REQ-012 SHALL register i_load once (i_load_q) and detect start as i_load && !i_load_q; start honoured in IDLE only, ignored elsewhere.
REQ-013 SHALL transition IDLE -> TEXT on start; TEXT -> TEXT_DONE on 16th accepted byte; TEXT_DONE -> KEY unconditionally; KEY -> KEY_DONE on 16th accepted byte; KEY_DONE -> IDLE unconditionally.
REQ-014 SHALL drive o_byte_ready = 1 in TEXT and KEY only; 0 in IDLE, TEXT_DONE, KEY_DONE.
REQ-015 SHALL accept a byte on a rising edge where i_byte_valid && o_byte_ready; no other byte is consumed.
REQ-016 SHALL shift each accepted byte into a 128-bit assembly register from the LSB end so the first byte ends at bits [127:120], the 16th at [7:0].
REQ-017 SHALL keep a 4-bit byte counter, cleared on entry to TEXT and KEY, incremented per accepted byte; 16th byte is the one accepted with counter = 15 (wraps to 0).
REQ-018 SHALL load data from the assembly register (including the 16th byte) on the edge entering TEXT_DONE / KEY_DONE; data otherwise holds its value, including through IDLE.
REQ-019 SHALL assert o_data_received_text exactly in TEXT_DONE and o_data_received_key exactly in KEY_DONE, with data already valid in that cycle (latency: 1 cycle from 16th byte edge).
REQ-020 SHALL tolerate i_byte_valid gaps of any length in TEXT/KEY without changing counter or assembly register.
REQ-021 SHALL treat i_load falling or re-rising mid-load as no effect; i_load held high after KEY_DONE SHALL NOT restart (no new edge).
REQ-022 SHALL drive all outputs from registers or state decode only; no combinational path from i_byte/i_byte_valid to outputs.

Reset
REQ-023 SHALL on reset force state IDLE, counter 0, assembly register 0, data 128'h0, i_load_q 0; o_byte_ready, o_data_received_text, o_data_received_key, o_busy all 0.
REQ-024 SHALL on reset mid-load discard partial bytes; after release a new i_load rising edge is required (i_load held high through reset is seen as edge only if i_load_q reset to 0, which is intended).

Structure
REQ-025 SHALL place state encoding (3-bit, IDLE=0..KEY_DONE=4), AES_BLOCK_BITS=128 and AES_BLOCK_BYTES=16 in the shared AES package/include used by the FSMs.
REQ-026 SHALL use one sub-module aes_byte_assembler (128-bit shift register + 4-bit counter, clear/shift/last outputs); FSM and output registers stay in aes_data_loader.

Verification
REQ-027 SHALL cover nominal: i_load rise, 16 bytes 54 77 6F 20 4F 6E 65 20 4E 69 6E 65 20 54 77 6F back-to-back -> one-cycle o_data_received_text with data=128'h54776F204F6E65204E696E652054776F; then 16 key bytes 54 68 61 74 73 20 6D 79 20 4B 75 6E 67 20 46 75 -> o_data_received_key with data=128'h5468617473206D79204B756E67204675, then o_busy=0.
REQ-028 SHALL cover valid gaps: same bytes with random 0-5 cycle idle gaps -> identical data values and single pulses.
REQ-029 SHALL cover backpressure: i_byte_valid held high through TEXT_DONE -> o_byte_ready=0 that cycle, 17th byte taken as key byte 0 in KEY, not lost or duplicated.
REQ-030 SHALL cover retrigger: i_load held high 60 cycles and pulsed again mid-KEY -> exactly one text and one key pulse, no restart.
REQ-031 SHALL cover reset mid-operation: reset after 7 text bytes -> all outputs 0, data=0; new i_load edge plus full sequence yields REQ-027 values.
